// File: rtl/fibonacci_core.sv
// Fibonacci term generator with programmable advance period and overflow restart.
// Term is registered: one cycle from prescaler tick to io_out; no backpressure, switch=0 stops immediately.
module fibonacci_core #(
    parameter int WIDTH       = 30,
    parameter int CLOCK_WIDTH = 6
) (
    input  logic                   wb_clk_i,
    input  logic                   reset_n,
    input  logic                   switch,
    input  logic [CLOCK_WIDTH-1:0] clock_sel,
    output logic [37:0]            io_out,
    output logic [37:0]            io_oeb,
    output logic                   valid,
    output logic                   wrapped,
    output logic [7:0]             wrap_count
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [CLOCK_WIDTH-1:0] presc;
    logic [CLOCK_WIDTH-1:0] clock_sel_q;
    logic [37:0]            oeb_q;
    logic [WIDTH:0]         sum;
    logic [CLOCK_WIDTH-1:0] last_count;
    logic                   sel_changed;

    // One extra bit so the carry out of WIDTH marks the overflow restart.
    assign sum         = {1'b0, a} + {1'b0, b};
    assign last_count  = clock_sel - CLOCK_WIDTH'(1);
    assign sel_changed = (clock_sel != clock_sel_q);

    assign io_out = {30'(a), 8'h00};
    assign io_oeb = oeb_q;

    always_ff @(posedge wb_clk_i) begin
        if (!reset_n) begin
            state       <= OFF;
            a           <= '0;
            b           <= WIDTH'(1);
            presc       <= '0;
            clock_sel_q <= '0;
            valid       <= 1'b0;
            wrapped     <= 1'b0;
            wrap_count  <= 8'd0;
            oeb_q       <= '1;
        end else begin
            clock_sel_q <= clock_sel;
            oeb_q       <= '0;
            valid       <= 1'b0;
            wrapped     <= 1'b0;
            case (state)
                OFF: begin
                    a     <= '0;
                    b     <= WIDTH'(1);
                    presc <= '0;
                    if (switch) begin
                        state <= SEED;
                    end
                end
                SEED: begin
                    a     <= '0;
                    b     <= WIDTH'(1);
                    presc <= '0;
                    valid <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    // Switch-off outranks a coincident tick: no pulse, no count change.
                    if (!switch) begin
                        state <= OFF;
                        a     <= '0;
                        b     <= WIDTH'(1);
                        presc <= '0;
                    end else if (clock_sel == '0 || sel_changed || presc >= clock_sel) begin
                        presc <= '0;
                    end else if (presc == last_count) begin
                        presc <= '0;
                        valid <= 1'b1;
                        if (sum[WIDTH]) begin
                            a       <= '0;
                            b       <= WIDTH'(1);
                            wrapped <= 1'b1;
                            if (wrap_count != 8'hff) begin
                                wrap_count <= wrap_count + 8'd1;
                            end
                        end else begin
                            a <= b;
                            b <= sum[WIDTH-1:0];
                        end
                    end else begin
                        presc <= presc + CLOCK_WIDTH'(1);
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_core.sv
// Directed bench for fibonacci_core; expected terms are queued as stimulus is applied and popped on valid.
module tb_fibonacci_core;

    localparam int WIDTH = 30;
    localparam int CW    = 6;

    logic          wb_clk_i = 1'b0;
    logic          reset_n;
    logic          switch;
    logic [CW-1:0] clock_sel;
    logic [37:0]   io_out;
    logic [37:0]   io_oeb;
    logic          valid;
    logic          wrapped;
    logic [7:0]    wrap_count;
    logic [29:0]   term;

    fibonacci_core #(.WIDTH(WIDTH), .CLOCK_WIDTH(CW)) dut (
        .wb_clk_i   (wb_clk_i),
        .reset_n    (reset_n),
        .switch     (switch),
        .clock_sel  (clock_sel),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .valid      (valid),
        .wrapped    (wrapped),
        .wrap_count (wrap_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    assign term = io_out[37:8];

    typedef struct {
        logic [29:0] term;
        logic        wr;
        logic [7:0]  wc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    longint      ma = 0;
    longint      mb = 1;
    int          mwc = 0;
    int          wraps = 0;
    logic [29:0] last_term = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_seed();
        ma = 0;
        mb = 1;
        sb.push_back('{term: 30'(0), wr: 1'b0, wc: 8'(mwc)});
    endtask

    // Reference advance: restart at 0 when the next sum no longer fits WIDTH bits.
    task automatic model_tick();
        longint s;
        s = ma + mb;
        if (s >= (longint'(1) << WIDTH)) begin
            ma = 0;
            mb = 1;
            if (mwc < 255) mwc++;
            wraps++;
            sb.push_back('{term: 30'(0), wr: 1'b1, wc: 8'(mwc)});
        end else begin
            ma = mb;
            mb = s;
            sb.push_back('{term: 30'(ma), wr: 1'b0, wc: 8'(mwc)});
        end
    endtask

    task automatic step_v(input logic exp_v);
        exp_t e;
        @(posedge wb_clk_i);
        #1;
        chk("valid", valid, exp_v);
        if (valid) begin
            chk("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("term", term, e.term);
                chk("wrapped", wrapped, e.wr);
                chk("wrap_count", wrap_count, e.wc);
                last_term = e.term;
            end
        end else begin
            chk("hold_term", term, last_term);
            chk("no_wrap", wrapped, 0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        switch    = 1'b0;
        clock_sel = '0;
        repeat (2) step_v(0);
        chk("rst_io_out", io_out, 0);
        chk("rst_io_oeb", io_oeb, {38{1'b1}});
        chk("rst_wrap_count", wrap_count, 0);

        reset_n = 1'b1;
        step_v(0);
        chk("oeb_driven", io_oeb, 0);
        step_v(0);
        chk("off_low_byte", io_out[7:0], 0);

        // clock_sel=1: 0,1,1,2,... every cycle, through F(43) and the overflow restart.
        switch    = 1'b1;
        clock_sel = 6'd1;
        step_v(0);
        push_seed();
        for (int i = 0; i < 46; i++) begin
            if (i > 0) model_tick();
            step_v(1);
            if (i == 43) chk("f43", term, 433494437);
            if (i == 44) begin
                chk("wrap_pulse", wrapped, 1);
                chk("wrap_count_1", wrap_count, 1);
                chk("wrap_term", term, 0);
            end
            if (i == 45) chk("after_wrap", term, 1);
        end
        chk("sb_empty_1", sb.size(), 0);

        // clock_sel=3: change edge restarts the count, then a tick every 3rd cycle.
        clock_sel = 6'd3;
        for (int j = 1; j <= 13; j++) begin
            if (j >= 4 && (j - 4) % 3 == 0) begin
                model_tick();
                step_v(1);
            end else begin
                step_v(0);
            end
        end

        // Switch falls exactly on a tick cycle: OFF wins.
        step_v(0);
        step_v(0);
        switch    = 1'b0;
        last_term = '0;
        step_v(0);
        chk("off_wrap_count", wrap_count, 1);
        step_v(0);
        switch = 1'b1;
        step_v(0);
        push_seed();
        step_v(1);
        step_v(0);
        step_v(0);
        model_tick();
        step_v(1);
        chk("sb_empty_2", sb.size(), 0);

        // clock_sel 4 -> 0 mid-count holds the term; then 2 ticks two edges after the change.
        clock_sel = 6'd4;
        repeat (3) step_v(0);
        clock_sel = 6'd0;
        repeat (10) step_v(0);
        clock_sel = 6'd2;
        step_v(0);
        step_v(0);
        model_tick();
        step_v(1);
        step_v(0);
        model_tick();
        step_v(1);

        // Run to wrap_count=5, then a one-cycle reset pulse mid-run.
        clock_sel = 6'd1;
        step_v(0);
        for (int n = 0; n < 300 && mwc < 5; n++) begin
            model_tick();
            step_v(1);
        end
        chk("wc5", wrap_count, 5);
        repeat (3) begin
            model_tick();
            step_v(1);
        end
        reset_n   = 1'b0;
        last_term = '0;
        sb.delete();
        step_v(0);
        chk("pulse_io_out", io_out, 0);
        chk("pulse_io_oeb", io_oeb, {38{1'b1}});
        chk("pulse_wrap_count", wrap_count, 0);
        reset_n = 1'b1;
        mwc     = 0;
        wraps   = 0;
        step_v(0);
        chk("seed_oeb", io_oeb, 0);
        push_seed();
        step_v(1);

        // Long run to confirm wrap_count saturates at 255.
        for (int n = 0; n < 12500 && wraps < 257; n++) begin
            model_tick();
            step_v(1);
        end
        chk("wraps_done", wraps, 257);
        chk("wc_saturated", wrap_count, 255);
        chk("sb_empty_3", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
